// File: rtl/sipo_deserializer_if.sv
// Bundle of the serial-side and parallel-side signals of the SIPO receiver.
// The slave modport is the receiver itself; master is whoever drives the wire and consumes words.
interface sipo_deserializer_if #(
    parameter int N = 3
) ();
    localparam int CW = $clog2(N + 1);

    logic          sin;
    logic          sin_valid;
    logic          sync;
    logic [N-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          overrun;
    logic          clr_overrun;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    modport master (
        output sin, sin_valid, sync, dout_ready, clr_overrun,
        input  dout, dout_valid, overrun, busy, bit_cnt
    );

    modport slave (
        input  sin, sin_valid, sync, dout_ready, clr_overrun,
        output dout, dout_valid, overrun, busy, bit_cnt
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: assembles N-bit words MSB-first and offers them
// on a one-entry valid/ready buffer with a sticky overrun flag.
module sipo_deserializer #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    sipo_deserializer_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    state_e        state_q, state_d;
    // Only N-1 history bits are kept: the newest bit comes straight from sin on completion.
    logic [N-2:0]  shiftReg_q, shiftReg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          doutValid_q, doutValid_d;
    logic          overrun_q, overrun_d;
    logic [N-1:0]  word;
    logic          complete;
    logic          dropWord;

    always_comb begin
        word        = {shiftReg_q, bus.sin};
        complete    = bus.sin_valid && !bus.sync && (cnt_q == CW'(N - 1));
        dropWord    = complete && doutValid_q && !bus.dout_ready;

        shiftReg_d  = bus.sin_valid ? word[N-2:0] : shiftReg_q;

        cnt_d = cnt_q;
        if (bus.sync) begin
            cnt_d = bus.sin_valid ? CW'(1) : '0;
        end else if (bus.sin_valid) begin
            cnt_d = complete ? '0 : cnt_q + CW'(1);
        end

        state_d = (cnt_d == '0) ? IDLE : COLLECT;

        // A completion can refill the buffer on the same edge the consumer drains it.
        dout_d      = dout_q;
        doutValid_d = doutValid_q;
        if (complete && !dropWord) begin
            dout_d      = word;
            doutValid_d = 1'b1;
        end else if (!complete && doutValid_q && bus.dout_ready) begin
            doutValid_d = 1'b0;
        end

        if (dropWord) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shiftReg_q  <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shiftReg_q  <= shiftReg_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = doutValid_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q == COLLECT);
    assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed scenarios followed by
// random traffic, all compared against a queue-based word-assembly model.
module tb_sipo_deserializer;
    localparam int N  = 3;
    localparam int CW = $clog2(N + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.N(N)) bus ();

    sipo_deserializer #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit           bitsQ[$];
    logic [N-1:0] mDout;
    bit           mValid;
    bit           mOver;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        bitsQ.delete();
        mDout  = '0;
        mValid = 1'b0;
        mOver  = 1'b0;
    endtask

    // Model: bits collect in a queue; when N are present they are weighted MSB-first into a word.
    task automatic modelStep(input bit sinV, input bit svV, input bit syncV, input bit readyV, input bit clrV);
        bit           done;
        bit           lost;
        int unsigned  value;
        done  = 1'b0;
        lost  = 1'b0;
        value = 0;
        if (syncV) bitsQ.delete();
        if (svV) begin
            bitsQ.push_back(sinV);
            if (bitsQ.size() == N) begin
                done = 1'b1;
                for (int i = 0; i < N; i++) value += int'(bitsQ[i]) * (2 ** (N - 1 - i));
                bitsQ.delete();
            end
        end
        if (done) begin
            if (!mValid || readyV) begin
                mDout  = N'(value);
                mValid = 1'b1;
            end else begin
                lost = 1'b1;
            end
        end else if (mValid && readyV) begin
            mValid = 1'b0;
        end
        if (lost) mOver = 1'b1;
        else if (clrV) mOver = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " dout_valid"}, 32'(bus.dout_valid), 32'(mValid));
        checkValue({tag, " overrun"}, 32'(bus.overrun), 32'(mOver));
        checkValue({tag, " busy"}, 32'(bus.busy), 32'(bitsQ.size() != 0));
        checkValue({tag, " bit_cnt"}, 32'(bus.bit_cnt), 32'(bitsQ.size()));
        if (mValid) checkValue({tag, " dout"}, 32'(bus.dout), 32'(mDout));
    endtask

    task automatic applyStimulus(input string tag, input bit sinV, input bit svV, input bit syncV,
                                 input bit readyV, input bit clrV);
        bus.sin         = sinV;
        bus.sin_valid   = svV;
        bus.sync        = syncV;
        bus.dout_ready  = readyV;
        bus.clr_overrun = clrV;
        @(posedge clk);
        #1;
        modelStep(sinV, svV, syncV, readyV, clrV);
        checkOutput(tag);
    endtask

    initial begin
        bus.sin         = 1'b0;
        bus.sin_valid   = 1'b0;
        bus.sync        = 1'b0;
        bus.dout_ready  = 1'b0;
        bus.clr_overrun = 1'b0;
        modelReset();

        #12;
        checkValue("reset dout", 32'(bus.dout), 32'd0);
        checkOutput("reset");
        rst_n = 1'b1;

        // Basic word 101 with the consumer always ready.
        applyStimulus("basic b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("basic b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("basic b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("basic dout", 32'(bus.dout), 32'b101);
        checkValue("basic valid", 32'(bus.dout_valid), 32'd1);
        applyStimulus("basic idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkValue("basic valid drop", 32'(bus.dout_valid), 32'd0);

        // Gapped bits 1,1,0.
        applyStimulus("gap b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("gap cnt1", 32'(bus.bit_cnt), 32'd1);
        applyStimulus("gap idle0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("gap b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("gap cnt2", 32'(bus.bit_cnt), 32'd2);
        applyStimulus("gap idle1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("gap b2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkValue("gap cnt0", 32'(bus.bit_cnt), 32'd0);
        checkValue("gap dout", 32'(bus.dout), 32'b110);

        // Drain, then stream 011 and 100 with the consumer stalled.
        applyStimulus("stall drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("stall b0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("stall b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("stall b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("stall b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("stall b4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("stall b5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkValue("stall dout", 32'(bus.dout), 32'b011);
        checkValue("stall overrun", 32'(bus.overrun), 32'd1);
        applyStimulus("stall clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkValue("stall overrun clr", 32'(bus.overrun), 32'd0);
        checkValue("stall dout kept", 32'(bus.dout), 32'b011);

        // Load 001, then complete 111 on the same edge it is dequeued.
        applyStimulus("swap drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("swap a0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("swap a1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("swap a2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("swap b0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("swap b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("swap b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("swap dout", 32'(bus.dout), 32'b111);
        checkValue("swap valid", 32'(bus.dout_valid), 32'd1);
        checkValue("swap overrun", 32'(bus.overrun), 32'd0);

        // Sync with a simultaneous bit restarts the word at count 1.
        applyStimulus("sync drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("sync b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("sync b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("sync edge", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkValue("sync cnt", 32'(bus.bit_cnt), 32'd1);
        applyStimulus("sync b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("sync b3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("sync dout", 32'(bus.dout), 32'b001);

        // Asynchronous reset between edges with a partial word and a held output.
        applyStimulus("arst b0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("arst b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkValue("arst dout", 32'(bus.dout), 32'd0);
        checkOutput("arst");
        #3;
        rst_n = 1'b1;
        applyStimulus("arst w0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("arst w1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("arst w2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("arst word", 32'(bus.dout), 32'b010);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($sformatf("rand%0d", i),
                          1'($urandom),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-to-parallel receiver that closes the link driven by the parallel-load/serial-shift register. It captures one serial bit per qualified clock and assembles N-bit words, first-received bit in the MSB. It presents each completed word on a one-entry valid/ready output buffer and flags overrun when the consumer stalls. It sits at the far end of the serial link, between the wire and any parallel consumer.

## Interface

- N, 3, word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge when high.
- sync  input  1  frame restart; discards any partial word.
- dout  output  N  completed word; stable while dout_valid is high.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when high together with dout_valid.
- overrun  output  1  sticky: a completed word was dropped.
- clr_overrun  input  1  synchronous clear of overrun.
- busy  output  1  partial word in progress (bit count nonzero).
- bit_cnt  output  clog2(N+1)  bits captured into the current partial word.

## Operation

- Internal shift register sr[N-1:0] and counter cnt, range 0..N-1.
- Accept: on a clk edge with sin_valid=1, sr <= {sr[N-2:0], sin} and cnt increments. The first accepted bit of a word ends in dout[N-1], the last in dout[0].
- Completion: an accept with cnt==N-1 finishes the word {sr[N-2:0], sin}, and cnt returns to 0. sr contents after completion are don't-care.
- Buffer load rules on a completion edge:
  - If dout_valid=0, or dout_valid=1 and dout_ready=1: dout <= completed word, and dout_valid is 1 after the edge.
  - If dout_valid=1 and dout_ready=0: the completed word is dropped, dout is unchanged, and overrun <= 1.
- Dequeue: an edge with dout_valid=1, dout_ready=1 and no completion sets dout_valid to 0. dout keeps its last value; the bench must not check it.
- sync=1 sets cnt to 0 and discards the partial word. If sin_valid=1 on the same edge, sin is taken as bit 1 of the new word, so cnt ends at 1. For N=2 this case does not complete a word. sync does not affect dout, dout_valid or overrun.
- overrun holds until clr_overrun=1. If clr_overrun and a new overrun event occur on the same edge, the set wins.
- busy = (cnt != 0). bit_cnt = cnt. Both are combinational from registers.
- There are only two states, IDLE (cnt==0) and COLLECT (cnt>0); no other FSM exists.

## Timing

- Reset (rst_n low, asynchronous): sr=0, cnt=0, dout=0, dout_valid=0, overrun=0, busy=0, bit_cnt=0.
- Reset release is synchronous to clk. The first edge with rst_n high may accept a bit.
- Reset asserted mid-word or while dout_valid=1 discards everything with no output.
- Latency: dout_valid rises on the same edge that samples the N-th bit, i.e. it is visible the cycle after the N-th sin_valid is presented.
- Throughput: one word per N cycles when sin_valid is continuous, with no bubbles, provided dout_ready is high on each completion edge.
- dout and dout_valid are registered outputs with no combinational path from any input.
- dout_ready has no effect when dout_valid=0.
- sin is ignored when sin_valid=0, and cnt holds. Gaps between bits are allowed at any position.

## Test plan

- Reset/basic (N=3): reset, then send bits 1,0,1 on consecutive cycles with dout_ready=1. Expect dout=3'b101 and dout_valid=1 for exactly one cycle, after which busy=0 and bit_cnt=0.
- Gapped input: send bits 1,1,0 with one idle cycle between each. Expect bit_cnt to step 1,2,0 and dout=3'b110 after the third bit.
- Back-to-back with stall: hold dout_ready=0 and stream 3'b011 followed by 3'b100. Expect dout=3'b011 to be retained and overrun=1 after the 6th bit. Then pulse clr_overrun and expect overrun=0 with dout still 3'b011.
- Simultaneous dequeue/complete: dout_valid=1 with 3'b001. Complete 3'b111 on the same edge that dout_ready=1. Expect dout=3'b111, dout_valid to stay 1, and overrun=0.
- Sync mid-word: send bits 1,1, then assert sync with sin_valid=1 and sin=0, then send 0,1. Expect dout=3'b001 and the first two bits discarded.
- Async reset mid-word: after 2 bits, and with dout_valid=1, pulse rst_n low between clock edges. Expect all outputs 0 immediately, then a clean 3-bit word of 3'b010 afterwards.
